drop_nth_packet_mc: RTL and testbench

//  Multi-channel successor of the single-counter Nth-packet dropper. Sits in the user data path

---
 rtl/drop_nth_packet_mc.sv | 152 +++++++++++++++
 tb/tb_drop_nth_packet_mc.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/drop_nth_packet_mc.sv
// Per-channel Nth-packet dropper with input FIFO and registered output stage.
// Optional statistics enabled by defining DROP_NTH_MC_STATS_EN.
module drop_nth_packet_mc #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = 8,
    parameter int NUM_CH          = 8,
    parameter int CNT_WIDTH       = 16,
    parameter int FIFO_DEPTH_BITS = 5,
    parameter int SRC_PORT_POS    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic [CNT_WIDTH-1:0]  cfg_n,
    input  logic [NUM_CH-1:0]     cfg_ch_en,
    output logic [31:0]           stat_drop,
    output logic [31:0]           stat_pass
);

    localparam int DEPTH   = 1 << FIFO_DEPTH_BITS;
    localparam int AW      = FIFO_DEPTH_BITS;
    localparam int CH_BITS = $clog2(NUM_CH);
    localparam int W       = DATA_WIDTH + CTRL_WIDTH;

    typedef enum logic [1:0] {SOP, HDR, DATA} state_t;

    state_t                 state;
    logic                   pkt_drop;
    logic [W-1:0]           mem [DEPTH];
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [AW:0]            fill;
    logic                   empty;
    logic                   full;
    logic                   wr_en;
    logic                   rd_en;
    logic [DATA_WIDTH-1:0]  head_data;
    logic [CTRL_WIDTH-1:0]  head_ctrl;
    logic [CH_BITS-1:0]     ch;
    logic [CNT_WIDTH-1:0]   cnt [NUM_CH];
    logic [CNT_WIDTH-1:0]   cfg_n_q;
    logic [NUM_CH-1:0]      cfg_en_q;
    logic                   cfg_chg;
    logic                   active;
    logic                   drop_now;
    logic                   cur_drop;
    logic                   sop_rd;

    assign fill      = wr_ptr - rd_ptr;
    assign empty     = (fill == '0);
    assign full      = (fill == (AW+1)'(DEPTH));
    assign in_rdy    = (fill < (AW+1)'(DEPTH - 2));
    assign wr_en     = in_wr && !full;
    assign {head_ctrl, head_data} = mem[rd_ptr[AW-1:0]];

    assign ch       = head_data[SRC_PORT_POS +: CH_BITS];
    assign active   = cfg_ch_en[ch] && (cfg_n != '0);
    assign drop_now = active && (cnt[ch] == cfg_n - CNT_WIDTH'(1));
    assign cur_drop = (state == SOP) ? drop_now : pkt_drop;
    // Dropped packets drain regardless of downstream backpressure
    assign rd_en    = !empty && (cur_drop || out_rdy);
    assign sop_rd   = rd_en && (state == SOP);
    assign cfg_chg  = (cfg_n != cfg_n_q) || (cfg_ch_en != cfg_en_q);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= {in_ctrl, in_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            state    <= SOP;
            pkt_drop <= 1'b0;
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
            cfg_n_q  <= '0;
            cfg_en_q <= '0;
        end else begin
            cfg_n_q  <= cfg_n;
            cfg_en_q <= cfg_ch_en;
            if (wr_en)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            out_wr <= rd_en && !cur_drop;
            if (rd_en && !cur_drop) begin
                out_data <= head_data;
                out_ctrl <= head_ctrl;
            end
            if (rd_en) begin
                unique case (state)
                    SOP: begin
                        pkt_drop <= drop_now;
                        state    <= HDR;
                    end
                    HDR:
                        if (head_ctrl == '0)
                            state <= DATA;
                    DATA:
                        if (head_ctrl != '0)
                            state <= SOP;
                    default:
                        state <= SOP;
                endcase
            end
        end
    end

    // A config change clears every counter and overrides any SOP update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++)
                cnt[i] <= '0;
        end else if (cfg_chg) begin
            for (int i = 0; i < NUM_CH; i++)
                cnt[i] <= '0;
        end else if (sop_rd && active) begin
            cnt[ch] <= drop_now ? '0 : cnt[ch] + CNT_WIDTH'(1);
        end
    end

`ifdef DROP_NTH_MC_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_drop <= '0;
            stat_pass <= '0;
        end else if (sop_rd) begin
            if (drop_now) begin
                if (stat_drop != '1)
                    stat_drop <= stat_drop + 32'd1;
            end else begin
                if (stat_pass != '1)
                    stat_pass <= stat_pass + 32'd1;
            end
        end
    end
`else
    assign stat_drop = '0;
    assign stat_pass = '0;
`endif

endmodule

// File: tb/tb_drop_nth_packet_mc.sv
// Directed bench for drop_nth_packet_mc: packet table plus
// hand-written backpressure, latency and reset sequences.
module tb_drop_nth_packet_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic [15:0] cfg_n;
    logic [7:0]  cfg_ch_en;
    logic [31:0] stat_drop;
    logic [31:0] stat_pass;

    int errors = 0;
    int checks = 0;
    int nwr = 0;

    logic [71:0] got[$];
    logic [71:0] exp_q[$];

    typedef struct {
        int         n;
        logic [7:0] en;
        int         port;
        bit         pass;
    } vec_t;

    vec_t tbl[$];

    drop_nth_packet_mc dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_wr     (in_wr),
        .in_rdy    (in_rdy),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_wr    (out_wr),
        .out_rdy   (out_rdy),
        .cfg_n     (cfg_n),
        .cfg_ch_en (cfg_ch_en),
        .stat_drop (stat_drop),
        .stat_pass (stat_pass)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (out_wr)
            got.push_back({out_ctrl, out_data});

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [71:0] mkword(int port, int tag, int i, int n);
        logic [7:0] c;
        c = (i == 0) ? 8'hFF : ((i == n - 1) ? 8'h01 : 8'h00);
        return {c, 16'(tag), 16'(i), 16'(port), 16'h0000};
    endfunction

    task automatic chk(string name, logic [71:0] act, logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic push_pkt(int port, int tag, int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(mkword(port, tag, i, n));
    endtask

    task automatic send_pkt(int port, int tag, int n, output bit ok);
        int tmo;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_wr = 1'b0;
            tmo = 0;
            while (!in_rdy && tmo < 300) begin
                @(negedge clk);
                tmo++;
            end
            if (tmo >= 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_rdy=0 want 1 (tag %0d)", tag);
                ok = 1'b0;
                return;
            end
            {in_ctrl, in_data} = mkword(port, tag, i, n);
            in_wr = 1'b1;
            nwr++;
        end
        @(negedge clk);
        in_wr = 1'b0;
    endtask

    task automatic check_stream(string name);
        int tmo;
        tmo = 0;
        while (got.size() < exp_q.size() && tmo < 600) begin
            @(negedge clk);
            tmo++;
        end
        repeat (10) @(negedge clk);
        chk({name, "_count"}, 72'(got.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk({name, "_word"}, got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    function automatic void add(int n, logic [7:0] en, int port, bit pass);
        vec_t v;
        v.n = n;
        v.en = en;
        v.port = port;
        v.pass = pass;
        tbl.push_back(v);
    endfunction

    initial begin
        bit ok;
        int sz;
        int nwr0;
        logic [31:0] exp_drop;
        logic [31:0] exp_pass;

        // cfg_n=3, ch 0: every 3rd packet dropped
        add(3, 8'h01, 0, 1); add(3, 8'h01, 0, 1); add(3, 8'h01, 0, 0);
        add(3, 8'h01, 0, 1); add(3, 8'h01, 0, 1); add(3, 8'h01, 0, 0);
        add(3, 8'h01, 0, 1); add(3, 8'h01, 0, 1); add(3, 8'h01, 0, 0);
        // cfg_n=2, ch 0/1 interleaved, independent counters
        add(2, 8'h03, 0, 1); add(2, 8'h03, 1, 1); add(2, 8'h03, 0, 0);
        add(2, 8'h03, 1, 0); add(2, 8'h03, 0, 1); add(2, 8'h03, 1, 1);
        // cfg_n=0: everything passes
        for (int k = 0; k < 20; k++)
            add(0, 8'hFF, k % 8, 1);
        // cfg_n=3 then 4: clear on change, 4th after change dropped
        add(3, 8'h01, 0, 1); add(3, 8'h01, 0, 1);
        add(4, 8'h01, 0, 1); add(4, 8'h01, 0, 1);
        add(4, 8'h01, 0, 1); add(4, 8'h01, 0, 0);
        // cfg_n=1: every packet of an enabled channel dropped
        add(1, 8'h04, 2, 0); add(1, 8'h04, 3, 1); add(1, 8'h04, 2, 0);

        reset = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        in_wr = 1'b0;
        out_rdy = 1'b1;
        cfg_n = '0;
        cfg_ch_en = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_wr", 72'(out_wr), 72'(0));
        chk("rst_out_data", 72'(out_data), 72'(0));
        chk("rst_out_ctrl", 72'(out_ctrl), 72'(0));
        chk("rst_in_rdy", 72'(in_rdy), 72'(1));
        chk("rst_stat_drop", 72'(stat_drop), 72'(0));
        chk("rst_stat_pass", 72'(stat_pass), 72'(0));
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Minimum latency: word written before edge A is out after edge B
        {in_ctrl, in_data} = mkword(5, 900, 0, 4);
        in_wr = 1'b1;
        @(negedge clk);
        in_wr = 1'b0;
        chk("lat_t1_out_wr", 72'(out_wr), 72'(0));
        @(negedge clk);
        chk("lat_t2_out_wr", 72'(out_wr), 72'(1));
        chk("lat_t2_word", {out_ctrl, out_data}, mkword(5, 900, 0, 4));
        for (int i = 1; i < 4; i++) begin
            {in_ctrl, in_data} = mkword(5, 900, i, 4);
            in_wr = 1'b1;
            @(negedge clk);
        end
        in_wr = 1'b0;
        push_pkt(5, 900, 4);

        for (int t = 0; t < tbl.size(); t++) begin
            if (32'(tbl[t].n) != 32'(cfg_n) || tbl[t].en != cfg_ch_en) begin
                repeat (60) @(negedge clk);
                cfg_n = 16'(tbl[t].n);
                cfg_ch_en = tbl[t].en;
                repeat (3) @(negedge clk);
            end
            send_pkt(tbl[t].port, t + 1, 4, ok);
            if (tbl[t].pass)
                push_pkt(tbl[t].port, t + 1, 4);
        end
        check_stream("table");

        // Backpressure on a forwarded packet, then drain of a dropped one
        cfg_n = 16'd2;
        cfg_ch_en = 8'h01;
        repeat (5) @(negedge clk);
        out_rdy = 1'b0;
        sz = got.size();
        nwr0 = nwr;
        fork
            send_pkt(0, 500, 40, ok);
            begin
                repeat (50) @(negedge clk);
                chk("stall_in_rdy", 72'(in_rdy), 72'(0));
                chk("stall_fill", 72'(nwr - nwr0), 72'(30));
                chk("stall_no_out", 72'(got.size()), 72'(sz));
                out_rdy = 1'b1;
            end
        join
        push_pkt(0, 500, 40);
        repeat (60) @(negedge clk);
        out_rdy = 1'b0;
        sz = got.size();
        send_pkt(0, 501, 45, ok);
        repeat (10) @(negedge clk);
        chk("drop_drained", 72'(ok), 72'(1));
        chk("drop_no_out", 72'(got.size()), 72'(sz));
        out_rdy = 1'b1;
        send_pkt(0, 502, 4, ok);
        push_pkt(0, 502, 4);
        check_stream("bp");

        // Reset mid-packet, then three clean packets with cfg_n=3
        cfg_n = 16'd3;
        cfg_ch_en = 8'h01;
        out_rdy = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            {in_ctrl, in_data} = mkword(0, 700, i, 4);
            in_wr = 1'b1;
            @(negedge clk);
        end
        in_wr = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++)
            send_pkt(0, 710 + k, 4, ok);
        push_pkt(0, 710, 4);
        push_pkt(0, 711, 4);
        check_stream("rst");
`ifdef DROP_NTH_MC_STATS_EN
        exp_drop = 32'd1;
        exp_pass = 32'd2;
`else
        exp_drop = 32'd0;
        exp_pass = 32'd0;
`endif
        chk("stat_drop", 72'(stat_drop), 72'(exp_drop));
        chk("stat_pass", 72'(stat_pass), 72'(exp_pass));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
